// File: rtl/led_pkg.sv
// Shared types for the LED pattern sequencer: mode encoding, debug view
// of the pattern state, and the mode/state -> LED vector decode.
package led_pkg;

  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    COUNT = 2'd1,
    BLINK = 2'd2,
    OFF   = 2'd3
  } mode_e;

  localparam int NUM_LEDS = 5;
  localparam int SCAN_MAX = 4;
  localparam int CLK_HZ   = 12000000;

  typedef struct packed {
    mode_e      mode;
    logic [2:0] scan_pos;
    logic       scan_up;
    logic [4:0] cnt;
    logic       blink_ph;
  } led_dbg_t;

  // OFF wraps back to SCAN through the 2-bit overflow.
  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

  function automatic logic [NUM_LEDS-1:0] led_decode(input mode_e      mode,
                                                     input logic [2:0] scan_pos,
                                                     input logic [4:0] cnt,
                                                     input logic       blink_ph);
    logic [NUM_LEDS-1:0] v;
    case (mode)
      SCAN:    v = NUM_LEDS'(1) << scan_pos;
      COUNT:   v = cnt;
      BLINK:   v = {NUM_LEDS{blink_ph}};
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser, level debounce and a one-cycle pulse on each
// accepted 0->1 transition of the button.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 120000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

  logic          meta_q, sync_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised input disagrees with the
  // accepted level; any agreement restarts the qualification window.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        level_d = sync_q;
        press_d = sync_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= btn_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Drives the five iCEstick user LEDs with one of four button-selected
// patterns stepped by a prescaled tick; pause freezes the stepping.
module led_pattern_sequencer
  import led_pkg::*;
#(
  parameter int unsigned STEP_DIV     = 2000000,
  parameter int unsigned DEBOUNCE_CYC = 120000
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     mode_btn,
  input  logic     pause,
  output logic     D1,
  output logic     D2,
  output logic     D3,
  output logic     D4,
  output logic     D5,
  output led_dbg_t dbg_o
);

  localparam int unsigned PW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;

  logic                press;
  logic                tick;
  logic                pause_meta_q, pause_sync_q;
  logic [PW-1:0]       presc_q;
  mode_e               mode_q;
  logic [2:0]          scan_pos_q;
  logic                scan_up_q;
  logic [4:0]          cnt_q;
  logic                blink_ph_q;
  logic [NUM_LEDS-1:0] led_q;

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (mode_btn),
    .press_o (press)
  );

  assign tick = (presc_q == PW'(STEP_DIV - 1)) && !pause_sync_q;

  // A press outranks a coincident tick: the new pattern starts clean and
  // the tick is dropped rather than applied to either pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pause_meta_q <= 1'b0;
      pause_sync_q <= 1'b0;
      presc_q      <= '0;
      mode_q       <= SCAN;
      scan_pos_q   <= '0;
      scan_up_q    <= 1'b1;
      cnt_q        <= '0;
      blink_ph_q   <= 1'b1;
      led_q        <= '0;
    end else begin
      pause_meta_q <= pause;
      pause_sync_q <= pause_meta_q;
      led_q        <= led_decode(mode_q, scan_pos_q, cnt_q, blink_ph_q);
      if (press) begin
        mode_q     <= next_mode(mode_q);
        presc_q    <= '0;
        scan_pos_q <= '0;
        scan_up_q  <= 1'b1;
        cnt_q      <= '0;
        blink_ph_q <= 1'b1;
      end else if (tick) begin
        presc_q <= '0;
        case (mode_q)
          SCAN: begin
            if (scan_up_q) begin
              if (scan_pos_q == 3'(SCAN_MAX)) begin
                scan_pos_q <= scan_pos_q - 3'd1;
                scan_up_q  <= 1'b0;
              end else begin
                scan_pos_q <= scan_pos_q + 3'd1;
              end
            end else begin
              if (scan_pos_q == 3'd0) begin
                scan_pos_q <= 3'd1;
                scan_up_q  <= 1'b1;
              end else begin
                scan_pos_q <= scan_pos_q - 3'd1;
              end
            end
          end
          COUNT:   cnt_q      <= cnt_q + 5'd1;
          BLINK:   blink_ph_q <= ~blink_ph_q;
          default: ;
        endcase
      end else if (!pause_sync_q) begin
        presc_q <= presc_q + PW'(1);
      end
    end
  end

  assign {D5, D4, D3, D2, D1} = led_q;
  assign dbg_o = {mode_q, scan_pos_q, scan_up_q, cnt_q, blink_ph_q};

endmodule
